// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end.
//   word_t        : 32-bit machine word
//   fetch_state_t : fetch FSM states
//   NOP_INSTR     : encoding used for IF/ID bubbles
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    REQ,
    SKID,
    DRAIN,
    HALT
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline latch.
// Priority: flush (bubble) > stall (hold) > load. Loading an invalid entry also yields a bubble.
// Ports:
//   clk_i, rst_ni              : clock, async active-low reset
//   flush_i, stall_i           : bubble / hold controls
//   load_valid_i, load_instr_i,
//   load_pc_i                  : candidate entry from fetch
//   valid_o, instr_o, pc_o,
//   npc_o                      : latched entry (npc = pc + 4)
module ifid_register
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  stall_i,
  input  logic  load_valid_i,
  input  word_t load_instr_i,
  input  word_t load_pc_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t pc_o,
  output word_t npc_o
);

  logic  valid_d, valid_q;
  word_t instr_d, instr_q;
  word_t pc_d, pc_q;
  word_t npc_d, npc_q;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    if (flush_i || (!stall_i && !load_valid_i)) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = '0;
      npc_d   = '0;
    end else if (!stall_i) begin
      valid_d = 1'b1;
      instr_d = load_instr_i;
      pc_d    = load_pc_i;
      npc_d   = load_pc_i + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      npc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem read handshake, skid buffer and IF/ID latch.
// Ports:
//   CLK, nRST                       : clock, async active-low reset
//   pc_en, stall_ifid, flush_ifid   : hazard-unit controls
//   redirect, redirect_pc           : taken branch/jump target
//   halt                            : stop fetching until reset
//   ihit, imemload                  : imem response
//   imemREN, imemaddr               : imem request (no combinational path from ihit)
//   ifid_valid/instr/pc/npc         : IF/ID latch to decode
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  pc_en,
  input  logic  stall_ifid,
  input  logic  flush_ifid,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output word_t ifid_npc
);

  fetch_state_t state_d, state_q;
  word_t        pc_d, pc_q;
  word_t        req_addr_d, req_addr_q;
  word_t        skid_instr_d, skid_instr_q;
  word_t        skid_pc_d, skid_pc_q;
  logic         halt_pend_d, halt_pend_q;

  logic  hold;
  logic  ifid_flush;
  logic  ifid_load_valid;
  word_t ifid_load_instr;
  word_t ifid_load_pc;

  assign hold = stall_ifid | ~pc_en;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_addr_d      = req_addr_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_d       = skid_pc_q;
    halt_pend_d     = halt_pend_q;
    ifid_flush      = flush_ifid | redirect;
    ifid_load_valid = 1'b0;
    ifid_load_instr = NOP_INSTR;
    ifid_load_pc    = '0;
    imemREN         = 1'b1;
    imemaddr        = pc_q;

    unique case (state_q)
      REQ: begin
        if (halt) begin
          ifid_flush = 1'b1;
          if (!ihit) begin
            // Let the outstanding miss finish on a frozen address before halting.
            halt_pend_d = 1'b1;
            req_addr_d  = pc_q;
            state_d     = DRAIN;
          end else begin
            state_d = HALT;
          end
        end else if (redirect) begin
          pc_d = redirect_pc;
          if (!ihit) begin
            req_addr_d = pc_q;
            state_d    = DRAIN;
          end
        end else if (ihit) begin
          pc_d = pc_q + 32'd4;
          if (hold) begin
            skid_instr_d = imemload;
            skid_pc_d    = pc_q;
            state_d      = SKID;
          end else begin
            ifid_load_valid = 1'b1;
            ifid_load_instr = imemload;
            ifid_load_pc    = pc_q;
          end
        end
      end
      SKID: begin
        imemREN = 1'b0;
        if (halt) begin
          ifid_flush   = 1'b1;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          state_d      = HALT;
        end else if (redirect) begin
          pc_d         = redirect_pc;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          state_d      = REQ;
        end else if (!hold) begin
          ifid_load_valid = 1'b1;
          ifid_load_instr = skid_instr_q;
          ifid_load_pc    = skid_pc_q;
          state_d         = REQ;
        end
      end
      DRAIN: begin
        imemaddr = req_addr_q;
        if (halt) begin
          ifid_flush = 1'b1;
          state_d    = HALT;
        end else begin
          if (redirect) pc_d = redirect_pc;
          if (ihit) state_d = halt_pend_q ? HALT : REQ;
        end
      end
      HALT: begin
        imemREN    = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= REQ;
      pc_q         <= PC_INIT;
      req_addr_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  ifid_register u_ifid_register (
    .clk_i        (CLK),
    .rst_ni       (nRST),
    .flush_i      (ifid_flush),
    .stall_i      (stall_ifid),
    .load_valid_i (ifid_load_valid),
    .load_instr_i (ifid_load_instr),
    .load_pc_i    (ifid_load_pc),
    .valid_o      (ifid_valid),
    .instr_o      (ifid_instr),
    .pc_o         (ifid_pc),
    .npc_o        (ifid_npc)
  );

endmodule
